// File: rtl/dma_request_arbiter.sv
// dma_request_arbiter
// Shares one DMA read engine between NUM_REQ requesters. A round-robin pick
// latches the winner's address/count, drives the DMA read handshake, waits for
// buffer-ready and returns a one-cycle done pulse to the winner. A watchdog
// aborts a transfer whose DMA never reports ready and raises a sticky error.

module dma_request_arbiter #(
  parameter int NUM_REQ           = 3,
  parameter int MEM_ADDRESS_WIDTH = 3,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     i_req,
  input  logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0]   i_req_address,
  input  logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0]   i_req_count,
  output logic [NUM_REQ-1:0]                     o_grant,
  output logic [NUM_REQ-1:0]                     o_done,
  output logic                                   o_dma_read,
  output logic [MEM_ADDRESS_WIDTH-1:0]           o_dma_address,
  output logic [MEM_ADDRESS_WIDTH-1:0]           o_dma_count,
  input  logic                                   i_dma_ready,
  output logic                                   o_busy,
  output logic                                   o_error
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int AW     = MEM_ADDRESS_WIDTH;

  // The watchdog fires on the last allowed cycle so a state lasts at most
  // TIMEOUT_CYCLES cycles before the abort edge.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_ISSUE      = 2'd1;
  localparam logic [1:0] S_WAIT_READY = 2'd2;
  localparam logic [1:0] S_DONE       = 2'd3;

  logic [1:0]           r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_read;
  logic [AW-1:0]        r_addr;
  logic [AW-1:0]        r_count;
  logic [WDOG_W-1:0]    r_wdog;
  logic                 r_error;
  logic                 r_mask;

  logic [NUM_REQ-1:0]   w_eligible;
  logic [NUM_REQ-1:0]   w_last_onehot;
  logic [NUM_REQ-1:0]   w_pick_onehot;
  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic [AW-1:0]        w_pick_addr;
  logic [AW-1:0]        w_pick_count;
  logic                 w_wdog_expired;
  int                   w_idx;

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IDX_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // The requester just served is masked for one IDLE cycle so it may drop its
  // level request a cycle late without being granted again.
  always_comb begin
    w_last_onehot = f_onehot(r_ptr);
    w_eligible    = r_mask ? (i_req & ~w_last_onehot) : i_req;
  end

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && w_eligible[w_idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(w_idx);
      end
    end
  end

  // Winner's address/count slices and one-hot grant vector.
  always_comb begin
    w_pick_onehot  = f_onehot(w_pick);
    w_pick_addr    = i_req_address[int'(w_pick)*AW +: AW];
    w_pick_count   = i_req_count[int'(w_pick)*AW +: AW];
    w_wdog_expired = (r_wdog == WDOG_LAST);
  end

  // Transaction FSM: grant, read handshake, watchdog and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_grant <= '0;
      r_done  <= '0;
      r_read  <= 1'b0;
      r_addr  <= '0;
      r_count <= '0;
      r_wdog  <= '0;
      r_error <= 1'b0;
      r_mask  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mask <= 1'b0;
          if (w_found) begin
            r_grant <= w_pick_onehot;
            r_ptr   <= w_pick;
            r_addr  <= w_pick_addr;
            r_count <= w_pick_count;
            r_wdog  <= '0;
            if (w_pick_count != '0) begin
              r_read  <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_done  <= w_pick_onehot;
              r_state <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (!i_dma_ready) begin
            r_wdog  <= '0;
            r_state <= S_WAIT_READY;
          end else if (w_wdog_expired) begin
            r_read  <= 1'b0;
            r_error <= 1'b1;
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        S_WAIT_READY: begin
          if (i_dma_ready) begin
            r_read  <= 1'b0;
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else if (w_wdog_expired) begin
            r_read  <= 1'b0;
            r_error <= 1'b1;
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_grant <= '0;
          r_mask  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Every output comes straight from a register so reset clears it at once.
  always_comb begin
    o_grant       = r_grant;
    o_done        = r_done;
    o_dma_read    = r_read;
    o_dma_address = r_addr;
    o_dma_count   = r_count;
    o_busy        = (r_state != S_IDLE);
    o_error       = r_error;
  end

endmodule

// File: tb/tb_dma_request_arbiter.sv
// tb_dma_request_arbiter
// Directed bench for dma_request_arbiter: single transfer, stale ready,
// zero-count transfer with the one-cycle eligibility mask, asynchronous reset
// mid-transfer, three-way contention and watchdog timeout.

module tb_dma_request_arbiter;

  localparam int NR = 3;
  localparam int AW = 3;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     i_req;
  logic [NR*AW-1:0]  i_req_address;
  logic [NR*AW-1:0]  i_req_count;
  logic [NR-1:0]     o_grant;
  logic [NR-1:0]     o_done;
  logic              o_dma_read;
  logic [AW-1:0]     o_dma_address;
  logic [AW-1:0]     o_dma_count;
  logic              i_dma_ready;
  logic              o_busy;
  logic              o_error;

  int total;
  int bad;

  dma_request_arbiter #(
    .NUM_REQ(NR),
    .MEM_ADDRESS_WIDTH(AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_req(i_req),
    .i_req_address(i_req_address),
    .i_req_count(i_req_count),
    .o_grant(o_grant),
    .o_done(o_done),
    .o_dma_read(o_dma_read),
    .o_dma_address(o_dma_address),
    .o_dma_count(o_dma_count),
    .i_dma_ready(i_dma_ready),
    .o_busy(o_busy),
    .o_error(o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] req, input logic [NR*AW-1:0] addr,
                               input logic [NR*AW-1:0] cnt, input logic rdy);
    i_req         = req;
    i_req_address = addr;
    i_req_count   = cnt;
    i_dma_ready   = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int expAddr[3];
    int expCount[3];
    total = 0;
    bad   = 0;
    expAddr  = '{0, 2, 5};
    expCount = '{2, 3, 1};

    // Reset state
    rst_n = 1'b0;
    applyStimulus(3'b000, '0, '0, 1'b0);
    #12;
    checkOutput("rst_grant", 32'(o_grant), 32'h0);
    checkOutput("rst_done", 32'(o_done), 32'h0);
    checkOutput("rst_read", 32'(o_dma_read), 32'h0);
    checkOutput("rst_addr", 32'(o_dma_address), 32'h0);
    checkOutput("rst_count", 32'(o_dma_count), 32'h0);
    checkOutput("rst_busy", 32'(o_busy), 32'h0);
    checkOutput("rst_error", 32'(o_error), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single request: req0 addr=1 count=4
    $display("[TB] single request");
    applyStimulus(3'b001, {3'd0, 3'd0, 3'd1}, {3'd0, 3'd0, 3'd4}, 1'b0);
    tick();
    checkOutput("single_grant", 32'(o_grant), 32'h1);
    checkOutput("single_read", 32'(o_dma_read), 32'h1);
    checkOutput("single_addr", 32'(o_dma_address), 32'h1);
    checkOutput("single_count", 32'(o_dma_count), 32'h4);
    checkOutput("single_busy", 32'(o_busy), 32'h1);
    tick();
    tick();
    checkOutput("single_wait_read", 32'(o_dma_read), 32'h1);
    checkOutput("single_wait_done", 32'(o_done), 32'h0);
    applyStimulus(3'b000, {3'd0, 3'd0, 3'd1}, {3'd0, 3'd0, 3'd4}, 1'b1);
    tick();
    checkOutput("single_done", 32'(o_done), 32'h1);
    checkOutput("single_done_grant", 32'(o_grant), 32'h1);
    checkOutput("single_done_read", 32'(o_dma_read), 32'h0);
    tick();
    checkOutput("single_idle_done", 32'(o_done), 32'h0);
    checkOutput("single_idle_grant", 32'(o_grant), 32'h0);
    checkOutput("single_idle_busy", 32'(o_busy), 32'h0);

    // Stale ready left high: arbiter must hold in ISSUE
    $display("[TB] stale ready");
    applyStimulus(3'b010, {3'd0, 3'd2, 3'd0}, {3'd0, 3'd3, 3'd0}, 1'b1);
    tick();
    checkOutput("stale_grant", 32'(o_grant), 32'h2);
    checkOutput("stale_addr", 32'(o_dma_address), 32'h2);
    checkOutput("stale_count", 32'(o_dma_count), 32'h3);
    tick();
    checkOutput("stale_hold1_done", 32'(o_done), 32'h0);
    checkOutput("stale_hold1_read", 32'(o_dma_read), 32'h1);
    tick();
    checkOutput("stale_hold2_done", 32'(o_done), 32'h0);
    i_dma_ready = 1'b0;
    tick();
    checkOutput("stale_wait_done", 32'(o_done), 32'h0);
    i_dma_ready = 1'b1;
    tick();
    checkOutput("stale_done", 32'(o_done), 32'h2);
    tick();
    checkOutput("stale_idle_busy", 32'(o_busy), 32'h0);

    // Zero count on req1; first IDLE cycle masks req1 (just served)
    $display("[TB] zero count with mask");
    applyStimulus(3'b010, {3'd0, 3'd6, 3'd0}, {3'd0, 3'd0, 3'd0}, 1'b0);
    tick();
    checkOutput("mask_grant", 32'(o_grant), 32'h0);
    checkOutput("mask_busy", 32'(o_busy), 32'h0);
    tick();
    checkOutput("zero_grant", 32'(o_grant), 32'h2);
    checkOutput("zero_done", 32'(o_done), 32'h2);
    checkOutput("zero_read", 32'(o_dma_read), 32'h0);
    checkOutput("zero_count", 32'(o_dma_count), 32'h0);
    applyStimulus(3'b000, {3'd0, 3'd6, 3'd0}, {3'd0, 3'd0, 3'd0}, 1'b0);
    tick();
    checkOutput("zero_idle_done", 32'(o_done), 32'h0);
    checkOutput("zero_idle_read", 32'(o_dma_read), 32'h0);

    // Reset during WAIT_READY
    $display("[TB] reset mid-transfer");
    applyStimulus(3'b001, {3'd0, 3'd0, 3'd1}, {3'd0, 3'd0, 3'd4}, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("mid_read_before", 32'(o_dma_read), 32'h1);
    #2;
    rst_n = 1'b0;
    applyStimulus(3'b111, {3'd5, 3'd2, 3'd0}, {3'd1, 3'd3, 3'd2}, 1'b0);
    #1;
    checkOutput("mid_rst_read", 32'(o_dma_read), 32'h0);
    checkOutput("mid_rst_grant", 32'(o_grant), 32'h0);
    checkOutput("mid_rst_busy", 32'(o_busy), 32'h0);
    checkOutput("mid_rst_done", 32'(o_done), 32'h0);
    #2;
    rst_n = 1'b1;

    // Contention: all three high, order 0,1,2,0 with one IDLE gap each
    $display("[TB] contention");
    for (int k = 0; k < 4; k++) begin
      int r;
      r = k % 3;
      tick();
      checkOutput($sformatf("cont%0d_grant", k), 32'(o_grant), 32'(1 << r));
      checkOutput($sformatf("cont%0d_addr", k), 32'(o_dma_address), 32'(expAddr[r]));
      checkOutput($sformatf("cont%0d_count", k), 32'(o_dma_count), 32'(expCount[r]));
      checkOutput($sformatf("cont%0d_read", k), 32'(o_dma_read), 32'h1);
      tick();
      i_dma_ready = 1'b1;
      tick();
      checkOutput($sformatf("cont%0d_done", k), 32'(o_done), 32'(1 << r));
      i_dma_ready = 1'b0;
      tick();
      checkOutput($sformatf("cont%0d_gap_grant", k), 32'(o_grant), 32'h0);
      checkOutput($sformatf("cont%0d_gap_done", k), 32'(o_done), 32'h0);
    end

    // Watchdog timeout on req2 with ready tied low
    $display("[TB] timeout");
    applyStimulus(3'b100, {3'd5, 3'd2, 3'd0}, {3'd1, 3'd3, 3'd2}, 1'b0);
    tick();
    checkOutput("to_grant", 32'(o_grant), 32'h4);
    tick();
    for (int c = 0; c < 7; c++) tick();
    checkOutput("to_read_last", 32'(o_dma_read), 32'h1);
    checkOutput("to_error_pre", 32'(o_error), 32'h0);
    applyStimulus(3'b000, {3'd5, 3'd2, 3'd0}, {3'd1, 3'd3, 3'd2}, 1'b0);
    tick();
    checkOutput("to_read_drop", 32'(o_dma_read), 32'h0);
    checkOutput("to_error", 32'(o_error), 32'h1);
    checkOutput("to_done", 32'(o_done), 32'h4);
    tick();
    checkOutput("to_idle_error", 32'(o_error), 32'h1);
    checkOutput("to_idle_done", 32'(o_done), 32'h0);

    // Normal transfer after timeout: error stays sticky
    $display("[TB] post-timeout transfer");
    applyStimulus(3'b001, {3'd5, 3'd2, 3'd3}, {3'd1, 3'd3, 3'd2}, 1'b0);
    tick();
    checkOutput("post_grant", 32'(o_grant), 32'h1);
    checkOutput("post_addr", 32'(o_dma_address), 32'h3);
    checkOutput("post_count", 32'(o_dma_count), 32'h2);
    tick();
    applyStimulus(3'b000, {3'd5, 3'd2, 3'd3}, {3'd1, 3'd3, 3'd2}, 1'b1);
    tick();
    checkOutput("post_done", 32'(o_done), 32'h1);
    checkOutput("post_error", 32'(o_error), 32'h1);
    tick();
    checkOutput("post_idle_busy", 32'(o_busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_request_arbiter.md
Name: dma_request_arbiter

Overview:
- Shares the single fully-connected DMA between NUM_REQ requesters, e.g. the input loader, the weight loader and the bias loader.
- Arbitrates round-robin and latches the winner's address/count.
- Drives the DMA read handshake, waits for buffer-ready and returns a one-cycle completion pulse to the winner.
- A watchdog flags a DMA that never reports ready.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MEM_ADDRESS_WIDTH, 3, width of memory address and count (matches DMA).
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT_READY before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  NUM_REQ  per-requester level request.
- i_req_address  in  NUM_REQ x MEM_ADDRESS_WIDTH  packed start address per requester.
- i_req_count  in  NUM_REQ x MEM_ADDRESS_WIDTH  packed word count per requester.
- o_grant  out  NUM_REQ  one-hot; high from grant through DONE.
- o_done  out  NUM_REQ  one-cycle pulse; DMA buffer valid for that requester.
- o_dma_read  out  1  drives DMA i_read.
- o_dma_address  out  MEM_ADDRESS_WIDTH  drives DMA i_address.
- o_dma_count  out  MEM_ADDRESS_WIDTH  drives DMA i_count.
- i_dma_ready  in  1  DMA o_ready.
- o_busy  out  1  high whenever state != IDLE.
- o_error  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; RR pointer=NUM_REQ-1, so requester 0 has first priority. All outputs are 0.
  - Applies mid-transaction too: o_dma_read drops immediately and no o_done is issued.
- States: IDLE, ISSUE, WAIT_READY, DONE.
- IDLE: if any eligible i_req, pick the first set bit searching from pointer+1 with wrap.
  - Next edge: o_grant=onehot(winner), o_dma_address/o_dma_count registered from the winner's slice, pointer=winner, o_busy=1.
  - If the latched count != 0, set o_dma_read=1 and go to ISSUE.
  - If the latched count == 0, go straight to DONE; o_dma_read is never asserted.
  - Latency from i_req high (sampled in IDLE) to grant/read: 1 cycle.
- ISSUE: o_dma_read held 1. Wait for i_dma_ready==0, which clears any stale ready from the previous transfer. Then go to WAIT_READY.
  - If ready is already 0 in the first ISSUE cycle, leave after 1 cycle.
- WAIT_READY: o_dma_read held 1. Watchdog counts from 0.
  - On i_dma_ready==1: next edge o_dma_read=0, state DONE.
  - If the counter reaches TIMEOUT_CYCLES first: o_dma_read=0, o_error=1 (sticky until reset), state DONE.
  - The ISSUE wait shares the same watchdog.
- DONE: exactly one cycle. o_done[winner]=1, o_grant still asserted. Next edge: o_grant=0, o_done=0, o_busy=0, state IDLE.
- Eligibility: in the first IDLE cycle after DONE, the just-served requester's i_req is masked, so a requester may drop i_req one cycle late. Afterwards it is eligible again at lowest RR priority.
- o_dma_address/o_dma_count are stable from grant until IDLE; requester inputs are ignored once latched.
- A requester deasserting i_req mid-transaction has no effect; the transaction completes and o_done still pulses.
- Simultaneous requests: one winner per transaction, no back-to-back grant to the same requester while others wait (starvation-free). Idle gap between transactions is 1 cycle (the IDLE cycle).
- o_grant is always one-hot or zero; o_done is a subset of o_grant.

Test Plan:
- Single request: DMA memory[i]=i, req0 addr=1 count=4 -> 1 cycle later grant=001, dma_read=1, addr=1, count=4. DMA ready -> done=001 for 1 cycle; DMA buffer = 1,2,3,4; busy drops the following cycle.
- Contention: all three requesters held high, counts 2/3/1, addrs 0/2/5 -> grant order 0,1,2,0,…. Each done pulse precedes the next grant by exactly 1 IDLE cycle; addr/count on DMA pins match the grantee each time.
- Zero count: req1 count=0 -> grant=010, dma_read never 1, done=010 two cycles after request, no DMA traffic.
- Stale ready: i_dma_ready left high from previous transfer -> arbiter remains in ISSUE until ready falls; done is not pulsed on the stale ready.
- Timeout: TIMEOUT_CYCLES=8, DMA tied ready=0 -> dma_read drops after 8 cycles in WAIT_READY, error=1 and stays 1, done pulses for the grantee. A later normal request completes with error still 1.
- Reset mid-transfer: rst_n low during WAIT_READY -> all outputs 0 without a clock edge, no done. After release, a pending req0 is granted first.
